operand_fetch_stage: RTL and testbench

- Decode-side operand stage sitting directly in front of the register file read ports and feeding the execute stage.
- Drives the register file read addresses and resolves RAW hazards by forwarding from EX/MEM/WB and by bypassing the same-cycle register file write.
- Detects load-use hazards and inserts bubbles; registers operands plus the immediate, PC, destination and control into the ID/EX pipeline register with a valid/ready handshake.

---
 rtl/operand_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_operand_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: register-file addressing, EX/MEM/WB forwarding, load-use stall, ID/EX register.
// Optional macro OPF_STALL_CNT_EN adds a 32-bit STALL_CNT output counting upstream stall cycles.
module operand_fetch_stage #(
    parameter int CTRL_W = 16,
    parameter int XLEN   = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [4:0]        IN_RS1,
    input  logic [4:0]        IN_RS2,
    input  logic [4:0]        IN_RD,
    input  logic              IN_USES_RS1,
    input  logic              IN_USES_RS2,
    input  logic [XLEN-1:0]   IN_IMM,
    input  logic [XLEN-1:0]   IN_PC,
    input  logic [CTRL_W-1:0] IN_CTRL,
    output logic [4:0]        RF_RADDR1,
    output logic [4:0]        RF_RADDR2,
    input  logic [XLEN-1:0]   RF_RDATA1,
    input  logic [XLEN-1:0]   RF_RDATA2,
    input  logic              EX_VALID,
    input  logic              EX_WE,
    input  logic              EX_IS_LOAD,
    input  logic [4:0]        EX_RD,
    input  logic [XLEN-1:0]   EX_RESULT,
    input  logic              MEM_WE,
    input  logic [4:0]        MEM_RD,
    input  logic [XLEN-1:0]   MEM_DATA,
    input  logic              WB_WE,
    input  logic [4:0]        WB_ADDR,
    input  logic [XLEN-1:0]   WB_DATA,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [XLEN-1:0]   OUT_RS1_DATA,
    output logic [XLEN-1:0]   OUT_RS2_DATA,
    output logic [XLEN-1:0]   OUT_IMM,
    output logic [XLEN-1:0]   OUT_PC,
    output logic [4:0]        OUT_RD,
    output logic [CTRL_W-1:0] OUT_CTRL
`ifdef OPF_STALL_CNT_EN
    ,
    output logic [31:0]       STALL_CNT
`endif
);

    logic [1:0][4:0]      src_idx;
    logic [1:0]           src_uses;
    logic [1:0][XLEN-1:0] src_rf;
    logic [1:0][XLEN-1:0] src_sel;
    logic [1:0]           src_haz;

    logic ex_fwd_ok;
    logic load_use;
    logic adv;
    logic transfer;

    logic              out_valid_reg;
    logic [XLEN-1:0]   out_rs1_reg;
    logic [XLEN-1:0]   out_rs2_reg;
    logic [XLEN-1:0]   out_imm_reg;
    logic [XLEN-1:0]   out_pc_reg;
    logic [4:0]        out_rd_reg;
    logic [CTRL_W-1:0] out_ctrl_reg;

    assign src_idx  = {IN_RS2, IN_RS1};
    assign src_uses = {IN_USES_RS2, IN_USES_RS1};
    assign src_rf   = {RF_RDATA2, RF_RDATA1};

    assign RF_RADDR1 = IN_RS1;
    assign RF_RADDR2 = IN_RS2;

    // A load in EX has no data yet, so it never forwards; it stalls instead.
    assign ex_fwd_ok = EX_VALID && EX_WE && !EX_IS_LOAD;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_sel[gi] =
                (src_idx[gi] == 5'd0)                    ? '0        :
                (ex_fwd_ok && EX_RD == src_idx[gi])      ? EX_RESULT :
                (MEM_WE && MEM_RD == src_idx[gi])        ? MEM_DATA  :
                (WB_WE && WB_ADDR == src_idx[gi])        ? WB_DATA   :
                                                           src_rf[gi];
            assign src_haz[gi] = src_uses[gi] && (src_idx[gi] == EX_RD);
        end
    endgenerate

    assign load_use = IN_VALID && EX_VALID && EX_IS_LOAD && (EX_RD != 5'd0) && (|src_haz);
    assign adv      = !out_valid_reg || OUT_READY;
    assign IN_READY = FLUSH || (adv && !load_use);
    assign transfer = IN_VALID && IN_READY && !FLUSH;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_reg <= 1'b0;
            out_rs1_reg   <= '0;
            out_rs2_reg   <= '0;
            out_imm_reg   <= '0;
            out_pc_reg    <= '0;
            out_rd_reg    <= '0;
            out_ctrl_reg  <= '0;
        end else if (FLUSH) begin
            out_valid_reg <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= transfer;
            if (transfer) begin
                out_rs1_reg  <= src_sel[0];
                out_rs2_reg  <= src_sel[1];
                out_imm_reg  <= IN_IMM;
                out_pc_reg   <= IN_PC;
                out_rd_reg   <= IN_RD;
                out_ctrl_reg <= IN_CTRL;
            end
        end
    end

    assign OUT_VALID    = out_valid_reg;
    assign OUT_RS1_DATA = out_rs1_reg;
    assign OUT_RS2_DATA = out_rs2_reg;
    assign OUT_IMM      = out_imm_reg;
    assign OUT_PC       = out_pc_reg;
    assign OUT_RD       = out_rd_reg;
    assign OUT_CTRL     = out_ctrl_reg;

`ifdef OPF_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_reg <= '0;
        end else if (IN_VALID && !IN_READY && !FLUSH) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign STALL_CNT = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed hazard/backpressure cases plus random traffic vs a model.
module tb_operand_fetch_stage;

    logic        CLK, RST_N;
    logic        IN_VALID, IN_READY;
    logic [4:0]  IN_RS1, IN_RS2, IN_RD;
    logic        IN_USES_RS1, IN_USES_RS2;
    logic [31:0] IN_IMM, IN_PC;
    logic [15:0] IN_CTRL;
    logic [4:0]  RF_RADDR1, RF_RADDR2;
    logic [31:0] RF_RDATA1, RF_RDATA2;
    logic        EX_VALID, EX_WE, EX_IS_LOAD;
    logic [4:0]  EX_RD;
    logic [31:0] EX_RESULT;
    logic        MEM_WE;
    logic [4:0]  MEM_RD;
    logic [31:0] MEM_DATA;
    logic        WB_WE;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic        FLUSH;
    logic        OUT_VALID, OUT_READY;
    logic [31:0] OUT_RS1_DATA, OUT_RS2_DATA, OUT_IMM, OUT_PC;
    logic [4:0]  OUT_RD;
    logic [15:0] OUT_CTRL;
`ifdef OPF_STALL_CNT_EN
    logic [31:0] STALL_CNT;
`endif

    operand_fetch_stage #(.CTRL_W(16), .XLEN(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_RD(IN_RD),
        .IN_USES_RS1(IN_USES_RS1), .IN_USES_RS2(IN_USES_RS2),
        .IN_IMM(IN_IMM), .IN_PC(IN_PC), .IN_CTRL(IN_CTRL),
        .RF_RADDR1(RF_RADDR1), .RF_RADDR2(RF_RADDR2),
        .RF_RDATA1(RF_RDATA1), .RF_RDATA2(RF_RDATA2),
        .EX_VALID(EX_VALID), .EX_WE(EX_WE), .EX_IS_LOAD(EX_IS_LOAD),
        .EX_RD(EX_RD), .EX_RESULT(EX_RESULT),
        .MEM_WE(MEM_WE), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA),
        .WB_WE(WB_WE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_RS1_DATA(OUT_RS1_DATA), .OUT_RS2_DATA(OUT_RS2_DATA),
        .OUT_IMM(OUT_IMM), .OUT_PC(OUT_PC), .OUT_RD(OUT_RD), .OUT_CTRL(OUT_CTRL)
`ifdef OPF_STALL_CNT_EN
        , .STALL_CNT(STALL_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the ID/EX register should hold.
    logic        m_valid;
    logic [31:0] m_rs1, m_rs2, m_imm, m_pc, m_rd, m_ctrl, m_stall;
    logic        cap_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Producers are applied oldest first so the youngest match overwrites the rest.
    function automatic logic [31:0] model_operand(input logic [4:0] rs, input logic [31:0] rf);
        logic [31:0] v;
        v = rf;
        if (WB_WE && WB_ADDR == rs) v = WB_DATA;
        if (MEM_WE && MEM_RD == rs) v = MEM_DATA;
        if (EX_VALID && EX_WE && !EX_IS_LOAD && EX_RD == rs) v = EX_RESULT;
        if (rs == 5'd0) v = 32'd0;
        return v;
    endfunction

    function automatic bit model_hazard();
        bit dep;
        dep = (IN_USES_RS1 && IN_RS1 == EX_RD) || (IN_USES_RS2 && IN_RS2 == EX_RD);
        return IN_VALID && EX_VALID && EX_IS_LOAD && EX_RD != 5'd0 && dep;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0; m_rd = 0; m_ctrl = 0; m_stall = 0;
    endtask

    task automatic compare_outputs(input string pfx, input bit all_fields);
        check({pfx, "_valid"}, 32'(OUT_VALID), 32'(m_valid));
        if (m_valid || all_fields) begin
            check({pfx, "_rs1"},  OUT_RS1_DATA, m_rs1);
            check({pfx, "_rs2"},  OUT_RS2_DATA, m_rs2);
            check({pfx, "_imm"},  OUT_IMM, m_imm);
            check({pfx, "_pc"},   OUT_PC, m_pc);
            check({pfx, "_rd"},   32'(OUT_RD), m_rd);
            check({pfx, "_ctrl"}, 32'(OUT_CTRL), m_ctrl);
        end
`ifdef OPF_STALL_CNT_EN
        check({pfx, "_stall_cnt"}, STALL_CNT, m_stall);
`endif
    endtask

    task automatic idle_inputs();
        IN_VALID = 0; IN_RS1 = 0; IN_RS2 = 0; IN_RD = 0; IN_USES_RS1 = 0; IN_USES_RS2 = 0;
        IN_IMM = 0; IN_PC = 0; IN_CTRL = 0; RF_RDATA1 = 0; RF_RDATA2 = 0;
        EX_VALID = 0; EX_WE = 0; EX_IS_LOAD = 0; EX_RD = 0; EX_RESULT = 0;
        MEM_WE = 0; MEM_RD = 0; MEM_DATA = 0; WB_WE = 0; WB_ADDR = 0; WB_DATA = 0;
        FLUSH = 0; OUT_READY = 1;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2);
        IN_VALID = 1; IN_RS1 = rs1; IN_RS2 = rs2; IN_USES_RS1 = u1; IN_USES_RS2 = u2;
        IN_RD = 5'($urandom_range(1, 31)); IN_IMM = $urandom; IN_PC = $urandom; IN_CTRL = 16'($urandom);
    endtask

    // Called just after a falling edge with inputs applied; returns just after the next falling edge.
    task automatic step(input string pfx);
        bit adv, haz, rdy;
        logic [31:0] s1, s2;
        #1;
        adv = !m_valid || OUT_READY;
        haz = model_hazard();
        rdy = FLUSH || (adv && !haz);
        cap_ready = IN_READY;
        check({pfx, "_in_ready"}, 32'(IN_READY), 32'(rdy));
        check({pfx, "_raddr"}, {RF_RADDR2, RF_RADDR1}, {IN_RS2, IN_RS1});
        s1 = model_operand(IN_RS1, RF_RDATA1);
        s2 = model_operand(IN_RS2, RF_RDATA2);
        if (IN_VALID && !rdy && !FLUSH) m_stall = m_stall + 32'd1;
        if (FLUSH) m_valid = 0;
        else if (adv) begin
            if (IN_VALID && !haz) begin
                m_valid = 1; m_rs1 = s1; m_rs2 = s2; m_imm = IN_IMM; m_pc = IN_PC;
                m_rd = 32'(IN_RD); m_ctrl = 32'(IN_CTRL);
            end else m_valid = 0;
        end
        @(posedge CLK); #1;
        compare_outputs(pfx, 0);
        @(negedge CLK);
    endtask

    task automatic rand_inputs();
        IN_VALID = ($urandom_range(0, 3) != 0);
        IN_RS1 = 5'($urandom_range(0, 7)); IN_RS2 = 5'($urandom_range(0, 7));
        IN_RD = 5'($urandom); IN_USES_RS1 = 1'($urandom); IN_USES_RS2 = 1'($urandom);
        IN_IMM = $urandom; IN_PC = $urandom; IN_CTRL = 16'($urandom);
        RF_RDATA1 = $urandom; RF_RDATA2 = $urandom;
        EX_VALID = 1'($urandom); EX_WE = 1'($urandom); EX_IS_LOAD = ($urandom_range(0, 2) == 0);
        EX_RD = 5'($urandom_range(0, 7)); EX_RESULT = $urandom;
        MEM_WE = 1'($urandom); MEM_RD = 5'($urandom_range(0, 7)); MEM_DATA = $urandom;
        WB_WE = 1'($urandom); WB_ADDR = 5'($urandom_range(0, 7)); WB_DATA = $urandom;
        FLUSH = ($urandom_range(0, 15) == 0);
        OUT_READY = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        RST_N = 0;
        #1;
        compare_outputs("reset", 1);
        @(negedge CLK); @(negedge CLK);
        RST_N = 1;

        // Plain register-file read.
        set_instr(5'd3, 5'd0, 1, 0); RF_RDATA1 = 32'h11;
        step("rf_read");
        check("rf_read_value", OUT_RS1_DATA, 32'h11);

        // EX beats MEM beats WB; x0 is always zero.
        set_instr(5'd5, 5'd5, 1, 1);
        EX_VALID = 1; EX_WE = 1; EX_RD = 5'd5; EX_RESULT = 32'hA;
        MEM_WE = 1; MEM_RD = 5'd5; MEM_DATA = 32'hB;
        WB_WE = 1; WB_ADDR = 5'd5; WB_DATA = 32'hC; RF_RDATA1 = 32'hDEAD;
        step("fwd_ex");
        check("fwd_ex_value", OUT_RS1_DATA, 32'hA);
        EX_VALID = 0;
        step("fwd_mem");
        check("fwd_mem_value", OUT_RS2_DATA, 32'hB);
        MEM_WE = 0;
        step("fwd_wb");
        check("fwd_wb_value", OUT_RS1_DATA, 32'hC);
        IN_RS1 = 5'd0; EX_VALID = 1; MEM_WE = 1; EX_RD = 5'd0; MEM_RD = 5'd0; WB_ADDR = 5'd0;
        step("fwd_x0");
        check("fwd_x0_value", OUT_RS1_DATA, 32'h0);

        // Load-use stall on rs2, then MEM forwarding resolves it.
        idle_inputs();
        set_instr(5'd1, 5'd7, 0, 1);
        EX_VALID = 1; EX_WE = 1; EX_IS_LOAD = 1; EX_RD = 5'd7;
        step("lu_stall");
        check("lu_stall_ready", 32'(cap_ready), 32'd0);
        check("lu_stall_bubble", 32'(OUT_VALID), 32'd0);
        EX_VALID = 0; EX_IS_LOAD = 0; MEM_WE = 1; MEM_RD = 5'd7; MEM_DATA = 32'h55;
        step("lu_resolve");
        check("lu_resolve_ready", 32'(cap_ready), 32'd1);
        check("lu_resolve_value", OUT_RS2_DATA, 32'h55);
        idle_inputs();
        set_instr(5'd1, 5'd7, 0, 0);
        EX_VALID = 1; EX_WE = 1; EX_IS_LOAD = 1; EX_RD = 5'd7;
        step("lu_unused");
        check("lu_unused_ready", 32'(cap_ready), 32'd1);

        // Backpressure for three cycles, then release.
        idle_inputs();
        set_instr(5'd2, 5'd4, 1, 1); RF_RDATA1 = 32'h1234; RF_RDATA2 = 32'h5678;
        step("bp_load");
        OUT_READY = 0;
        set_instr(5'd6, 5'd6, 1, 1); RF_RDATA1 = 32'h9999;
        for (int i = 0; i < 3; i++) begin
            step("bp_hold");
            check("bp_hold_ready", 32'(cap_ready), 32'd0);
            check("bp_hold_rs1", OUT_RS1_DATA, 32'h1234);
        end
        OUT_READY = 1;
        step("bp_release");
        check("bp_release_rs1", OUT_RS1_DATA, 32'h9999);

        // FLUSH under backpressure drops both the held output and the input.
        OUT_READY = 0;
        set_instr(5'd3, 5'd3, 1, 1); FLUSH = 1;
        step("flush");
        check("flush_ready", 32'(cap_ready), 32'd1);
        check("flush_valid", 32'(OUT_VALID), 32'd0);
        FLUSH = 0; OUT_READY = 1;
        step("post_flush");

        // Reset asserted mid-stall returns everything to zero at once.
        OUT_READY = 0;
        set_instr(5'd4, 5'd7, 1, 1);
        EX_VALID = 1; EX_WE = 1; EX_IS_LOAD = 1; EX_RD = 5'd7;
        #2;
        RST_N = 0;
        #1;
        model_reset();
        compare_outputs("rst_mid", 1);
        @(negedge CLK);
        RST_N = 1;
        idle_inputs();

`ifdef OPF_STALL_CNT_EN
        // Four consecutive load-use stall cycles from a freshly reset counter.
        set_instr(5'd7, 5'd0, 1, 0);
        EX_VALID = 1; EX_WE = 1; EX_IS_LOAD = 1; EX_RD = 5'd7;
        for (int i = 0; i < 4; i++) step("stall_cnt");
        check("stall_cnt_four", STALL_CNT, 32'd4);
        idle_inputs();
`endif

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
